// File: rtl/map_loader_pkg.sv
// Shared game constants and the map loader state encoding.
package map_loader_pkg;

    localparam int CELLS  = 81;
    localparam int VAL_W  = 4;
    localparam int VIS_W  = 2;
    localparam int ADDR_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_STREAM  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/map_loader.sv
// Loads a puzzle: drives the selector difficulty, snapshots its map/visibility buses, streams one cell per write.
// Latency: SETTLE+1+CELLS+1 cycles from the start edge to the end of the done cycle with wr_ready held high.
// Backpressure: wr_ready low freezes the current write (addr/value/vis held) indefinitely; start is dropped while busy.
module map_loader #(
    parameter int CELLS  = map_loader_pkg::CELLS,
    parameter int VAL_W  = map_loader_pkg::VAL_W,
    parameter int VIS_W  = map_loader_pkg::VIS_W,
    parameter int SETTLE = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                difficulty,
    output logic                                sel_difficulty,
    input  logic [CELLS*VAL_W-1:0]              map_in,
    input  logic [CELLS*VIS_W-1:0]              vis_in,
    output logic                                wr_valid,
    input  logic                                wr_ready,
    output logic [map_loader_pkg::ADDR_W-1:0]   wr_addr,
    output logic [VAL_W-1:0]                    wr_value,
    output logic [VIS_W-1:0]                    wr_vis,
    output logic                                busy,
    output logic                                done
);
    import map_loader_pkg::*;

    localparam int MAP_W = CELLS * VAL_W;
    localparam int VSB_W = CELLS * VIS_W;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(CELLS - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   settle_cnt;
    logic [ADDR_W-1:0]  idx;
    logic [MAP_W-1:0]   map_sr;
    logic [VSB_W-1:0]   vis_sr;
    logic               sel_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_valid  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                wr_valid = 1'b1;
                if (wr_ready && (idx == LAST_ADDR)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The current cell always sits in the low bits of the snapshot; each accepted write shifts the next one in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q      <= 1'b0;
            settle_cnt <= '0;
            idx        <= '0;
            map_sr     <= '0;
            vis_sr     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sel_q      <= difficulty;
                        settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                ST_CAPTURE: begin
                    map_sr <= map_in;
                    vis_sr <= vis_in;
                    idx    <= '0;
                end
                ST_STREAM: begin
                    if (wr_ready) begin
                        map_sr <= map_sr >> VAL_W;
                        vis_sr <= vis_sr >> VIS_W;
                        if (idx != LAST_ADDR) begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sel_difficulty = sel_q;
    assign wr_addr        = idx;
    assign wr_value       = map_sr[VAL_W-1:0];
    assign wr_vis         = vis_sr[VIS_W-1:0];

endmodule
